// File: rtl/bmd_256_latency_drain.sv
// Drains the arrival-timestamp FIFO on trigger, emitting mod-2^TS_W deltas packed two per 64-bit beat.
// One FIFO read per 3 cycles; the output beat holds under !m_ready and stalls further reads.
module bmd_256_latency_drain #(
  parameter int TS_W  = 30,
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             latency_reset_signal,
  input  logic             fifo_read_trigger,
  input  logic             fifo_counter_empty_out,
  input  logic [TS_W-1:0]  fifo_counter_value_out,
  output logic             fifo_counter_read_en,
  output logic [63:0]      m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CNT_W-1:0] pass_count,
  output logic [TS_W-1:0]  max_delta,
  output logic             pass_done
);

  localparam int PAD = 31 - TS_W;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_CHECK, S_FLUSH, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TS_W-1:0]  r_prev;
  logic [TS_W-1:0]  r_delta;
  logic [31:0]      r_lane0;
  logic             r_half;
  logic             r_read_en;
  logic [63:0]      r_m_data;
  logic             r_m_valid;
  logic             r_m_last;
  logic [CNT_W-1:0] r_pass_count;
  logic [TS_W-1:0]  r_max_delta;
  logic             r_pass_done;

  logic             w_rst;
  logic             w_out_free;
  logic [TS_W-1:0]  w_delta;
  logic [31:0]      w_lane_new;
  logic             w_start;
  logic             w_store_lane0;
  logic             w_load_beat;
  logic [63:0]      w_beat_data;
  logic             w_beat_last;

  assign w_rst      = !rst_n || latency_reset_signal;
  assign w_out_free = !r_m_valid || m_ready;
  assign w_delta    = fifo_counter_value_out - r_prev;
  assign w_lane_new = {1'b1, {PAD{1'b0}}, r_delta};

  always_comb begin
    w_next        = r_state;
    w_start       = 1'b0;
    w_store_lane0 = 1'b0;
    w_load_beat   = 1'b0;
    w_beat_data   = r_m_data;
    w_beat_last   = r_m_last;
    case (r_state)
      S_IDLE: begin
        if (fifo_read_trigger) begin
          w_start = 1'b1;
          w_next  = S_READ;
        end
      end
      S_READ:  w_next = S_LATCH;
      S_LATCH: w_next = S_CHECK;
      S_CHECK: begin
        // empty_out here already reflects the read issued two cycles earlier
        if (!r_half) begin
          w_store_lane0 = 1'b1;
          w_next        = fifo_counter_empty_out ? S_FLUSH : S_READ;
        end else if (w_out_free) begin
          w_load_beat = 1'b1;
          w_beat_data = {w_lane_new, r_lane0};
          w_beat_last = fifo_counter_empty_out;
          w_next      = fifo_counter_empty_out ? S_DONE : S_READ;
        end
      end
      S_FLUSH: begin
        if (w_out_free) begin
          w_load_beat = 1'b1;
          w_beat_data = {32'h0, r_lane0};
          w_beat_last = 1'b1;
          w_next      = S_DONE;
        end
      end
      S_DONE: begin
        // a trigger left high from this pass must not re-arm
        if (!r_m_valid && !fifo_read_trigger) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state      <= S_IDLE;
      r_prev       <= '0;
      r_delta      <= '0;
      r_lane0      <= '0;
      r_half       <= 1'b0;
      r_read_en    <= 1'b0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_pass_count <= '0;
      r_max_delta  <= '0;
      r_pass_done  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_read_en   <= (w_next == S_READ);
      r_pass_done <= (r_state == S_DONE) && r_m_valid && r_m_last && m_ready;

      if (w_start) begin
        r_prev       <= '0;
        r_half       <= 1'b0;
        r_pass_count <= '0;
        r_max_delta  <= '0;
      end

      if (r_state == S_LATCH) begin
        r_delta <= w_delta;
        r_prev  <= fifo_counter_value_out;
        if (r_pass_count != {CNT_W{1'b1}}) r_pass_count <= r_pass_count + CNT_W'(1);
        if (w_delta > r_max_delta) r_max_delta <= w_delta;
      end

      if (w_store_lane0) begin
        r_lane0 <= w_lane_new;
        r_half  <= 1'b1;
      end

      if (w_load_beat) begin
        r_m_data  <= w_beat_data;
        r_m_last  <= w_beat_last;
        r_m_valid <= 1'b1;
        r_half    <= 1'b0;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign fifo_counter_read_en = r_read_en;
  assign m_data               = r_m_data;
  assign m_valid              = r_m_valid;
  assign m_last               = r_m_last;
  assign pass_count           = r_pass_count;
  assign max_delta            = r_max_delta;
  assign pass_done            = r_pass_done;

endmodule

// File: tb/tb_bmd_256_latency_drain.sv
`timescale 1ns/1ps
module tb_bmd_256_latency_drain;
  localparam int TS_W  = 30;
  localparam int CNT_W = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             latency_reset_signal = 1'b0;
  logic             fifo_read_trigger = 1'b0;
  logic             fifo_counter_empty_out = 1'b1;
  logic [TS_W-1:0]  fifo_counter_value_out = '0;
  logic             fifo_counter_read_en;
  logic [63:0]      m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready = 1'b1;
  logic [CNT_W-1:0] pass_count;
  logic [TS_W-1:0]  max_delta;
  logic             pass_done;

  always #2 clk = ~clk;

  bmd_256_latency_drain #(.TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .latency_reset_signal   (latency_reset_signal),
    .fifo_read_trigger      (fifo_read_trigger),
    .fifo_counter_empty_out (fifo_counter_empty_out),
    .fifo_counter_value_out (fifo_counter_value_out),
    .fifo_counter_read_en   (fifo_counter_read_en),
    .m_data                 (m_data),
    .m_valid                (m_valid),
    .m_last                 (m_last),
    .m_ready                (m_ready),
    .pass_count             (pass_count),
    .max_delta              (max_delta),
    .pass_done              (pass_done)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        last;
  } beat_t;

  beat_t           exp_q[$];
  logic [TS_W-1:0] fifo_q[$];
  logic [TS_W-1:0] stim[$];

  int n_checks = 0, n_fail = 0;
  int n_reads = 0, n_done = 0, cyc = 0;
  int first_read_cyc = -1, last_read_cyc = -1, first_valid_cyc = -1;
  int min_gap = 1 << 30, max_gap = 0;
  int trig_cyc = 0;
  logic        hold_prev = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;
  beat_t       mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous FIFO: dout one cycle after read_en, empty flag one cycle late
  always @(posedge clk) begin
    fifo_counter_empty_out <= (fifo_q.size() == 0);
    if (fifo_counter_read_en && fifo_q.size() > 0)
      fifo_counter_value_out <= fifo_q.pop_front();
  end

  always @(negedge clk) begin
    if (fifo_counter_read_en === 1'b1) begin
      n_reads++;
      if (first_read_cyc < 0) first_read_cyc = cyc;
      if (last_read_cyc >= 0) begin
        if (cyc - last_read_cyc < min_gap) min_gap = cyc - last_read_cyc;
        if (cyc - last_read_cyc > max_gap) max_gap = cyc - last_read_cyc;
      end
      last_read_cyc = cyc;
    end
    if (pass_done === 1'b1) n_done++;
    if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_valid === 1'b1 && hold_prev) begin
      n_checks++;
      if (m_data !== prev_data || m_last !== prev_last) begin
        n_fail++;
        $display("FAIL hold_stable: m_data=%h last=%b, required %h last=%b", m_data, m_last, prev_data, prev_last);
      end
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: m_data=%h last=%b, required no beat", m_data, m_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_data !== mon_e.d || m_last !== mon_e.last) begin
          n_fail++;
          $display("FAIL beat_data: m_data=%h last=%b, required %h last=%b", m_data, m_last, mon_e.d, mon_e.last);
        end
      end
    end
    hold_prev = (m_valid === 1'b1) && (m_ready !== 1'b1);
    prev_data = m_data;
    prev_last = m_last;
  end

  task automatic push_beat(input logic [63:0] d, input logic last);
    beat_t b;
    b.d = d;
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Loads stim into the FIFO and queues the beats a correct drain must produce
  task automatic load_stim();
    logic [TS_W-1:0] prev, dl;
    logic [31:0]     lane0;
    bit              half;
    prev = '0; half = 0; lane0 = '0;
    for (int i = 0; i < stim.size(); i++) begin
      fifo_q.push_back(stim[i]);
      dl = stim[i] - prev;
      prev = stim[i];
      if (!half) begin
        lane0 = {2'b10, dl};
        half = 1;
      end else begin
        push_beat({2'b10, dl, lane0}, i == stim.size() - 1);
        half = 0;
      end
    end
    if (half) push_beat({32'h0, lane0}, 1'b1);
    stim.delete();
  endtask

  task automatic clear_stats();
    n_reads = 0; first_read_cyc = -1; last_read_cyc = -1; first_valid_cyc = -1;
    min_gap = 1 << 30; max_gap = 0;
  endtask

  task automatic pulse_trigger();
    fifo_read_trigger = 1'b1;
    trig_cyc = cyc;
    @(posedge clk); #1;
    fifo_read_trigger = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = n_done;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (n_done > start) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({fifo_counter_read_en, m_valid, m_last, pass_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: {rd,vld,last,done}=%b, required 0000", {fifo_counter_read_en, m_valid, m_last, pass_done});
    end
    n_checks++;
    if (m_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: %h, required 0", m_data); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (pass_count !== '0 || max_delta !== '0) begin
      n_fail++;
      $display("FAIL reset_stats: count=%0d max=%0d, required 0 0", pass_count, max_delta);
    end
    n_checks++;
    if (n_reads != 0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: reads=%0d vld=%b, required 0 0", n_reads, m_valid);
    end
  endtask

  task automatic test_basic_even();
    bit ok;
    clear_stats();
    fifo_q.push_back(30'd100); fifo_q.push_back(30'd250);
    fifo_q.push_back(30'd1000); fifo_q.push_back(30'd1001);
    push_beat(64'h80000096_80000064, 1'b0);
    push_beat(64'h80000001_800002EE, 1'b1);
    pulse_trigger();
    wait_done(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: no pass_done, required one within 200 cycles"); end
    n_checks++;
    if (first_read_cyc != trig_cyc + 1) begin
      n_fail++; $display("FAIL basic_read_latency: %0d, required %0d", first_read_cyc - trig_cyc, 1);
    end
    n_checks++;
    if (first_valid_cyc != trig_cyc + 7) begin
      n_fail++; $display("FAIL basic_beat_latency: %0d, required %0d", first_valid_cyc - trig_cyc, 7);
    end
    n_checks++;
    if (n_reads != 4 || min_gap != 3 || max_gap != 3) begin
      n_fail++; $display("FAIL basic_reads: n=%0d gaps=%0d..%0d, required 4 gaps 3..3", n_reads, min_gap, max_gap);
    end
    n_checks++;
    if (pass_count !== 14'd4 || max_delta !== 30'd750) begin
      n_fail++; $display("FAIL basic_stats: count=%0d max=%0d, required 4 750", pass_count, max_delta);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_beats_left: %0d, required 0", exp_q.size()); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_odd();
    bit ok;
    int d0;
    clear_stats();
    d0 = n_done;
    stim.push_back(30'd10); stim.push_back(30'd30); stim.push_back(30'd70);
    load_stim();
    pulse_trigger();
    wait_done(200, ok);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (!ok || n_done - d0 != 1) begin
      n_fail++; $display("FAIL odd_done_pulses: %0d, required 1", n_done - d0);
    end
    n_checks++;
    if (pass_count !== 14'd3 || max_delta !== 30'd40) begin
      n_fail++; $display("FAIL odd_stats: count=%0d max=%0d, required 3 40", pass_count, max_delta);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL odd_beats_left: %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_stats();
    stim.push_back(30'h3FFFFFFF); stim.push_back(30'h5);
    load_stim();
    pulse_trigger();
    wait_done(200, ok);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!ok || max_delta !== 30'h3FFFFFFF || pass_count !== 14'd2) begin
      n_fail++; $display("FAIL wrap_stats: done=%0d count=%0d max=%h, required 1 2 3fffffff", ok, pass_count, max_delta);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_beats_left: %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    int r0, rdy_cyc;
    logic [63:0] snap;
    clear_stats();
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) stim.push_back(30'(5 << k));
    load_stim();
    pulse_trigger();
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (m_valid === 1'b1) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL bp_first_beat: m_valid never rose, required within 50 cycles"); end
    repeat (8) @(posedge clk);
    #1;
    snap = m_data;
    r0 = n_reads;
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (n_reads != r0 || m_data !== snap) begin
      n_fail++; $display("FAIL bp_stall: reads=%0d data=%h, required reads=%0d data=%h", n_reads, m_data, r0, snap);
    end
    m_ready = 1'b1;
    rdy_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (n_reads > r0) break;
    end
    n_checks++;
    if (n_reads == r0 || last_read_cyc != rdy_cyc + 1) begin
      n_fail++; $display("FAIL bp_resume: read at +%0d, required +1", last_read_cyc - rdy_cyc);
    end
    wait_done(200, ok);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!ok || pass_count !== 14'd6 || max_delta !== 30'd80 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_end: done=%0d count=%0d max=%0d left=%0d, required 1 6 80 0", ok, pass_count, max_delta, exp_q.size());
    end
  endtask

  task automatic test_full_pass();
    bit ok;
    int d0;
    clear_stats();
    d0 = n_done;
    for (int k = 0; k < 8192; k++) stim.push_back(30'(3 * k));
    load_stim();
    fifo_read_trigger = 1'b1;
    wait_done(30000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_timeout: no pass_done, required within 30000 cycles"); end
    n_checks++;
    if (n_reads != 8192 || pass_count !== 14'd8192 || max_delta !== 30'd3) begin
      n_fail++; $display("FAIL full_stats: reads=%0d count=%0d max=%0d, required 8192 8192 3", n_reads, pass_count, max_delta);
    end
    repeat (50) @(posedge clk);
    #1;
    n_checks++;
    if (n_reads != 8192 || n_done - d0 != 1) begin
      n_fail++; $display("FAIL full_no_rearm: reads=%0d dones=%0d, required 8192 1", n_reads, n_done - d0);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_beats_left: %0d, required 0", exp_q.size()); end
    fifo_read_trigger = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    bit ok;
    clear_stats();
    for (int k = 1; k <= 10; k++) fifo_q.push_back(30'(7 * k));
    push_beat(64'h80000007_80000007, 1'b0);
    pulse_trigger();
    for (int i = 0; i < 100 && n_reads < 4; i++) begin @(posedge clk); #1; end
    m_ready = 1'b0;
    for (int i = 0; i < 100 && n_reads < 5; i++) begin @(posedge clk); #1; end
    latency_reset_signal = 1'b1;
    @(posedge clk); #1;
    latency_reset_signal = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || pass_count !== '0 || max_delta !== '0) begin
      n_fail++; $display("FAIL abort_clear: vld=%b count=%0d max=%0d, required 0 0 0", m_valid, pass_count, max_delta);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (n_reads != 5 || m_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL abort_idle: reads=%0d vld=%b left=%0d, required 5 0 0", n_reads, m_valid, exp_q.size());
    end
    fifo_q.delete();
    clear_stats();
    fifo_q.push_back(30'd50); fifo_q.push_back(30'd60);
    push_beat(64'h8000000A_80000032, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    pulse_trigger();
    wait_done(200, ok);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!ok || pass_count !== 14'd2 || max_delta !== 30'd50 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL abort_fresh: done=%0d count=%0d max=%0d left=%0d, required 1 2 50 0", ok, pass_count, max_delta, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_even();
    test_odd();
    test_wrap();
    test_backpressure();
    test_full_pass();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
